// File: rtl/fan_gov_pkg.sv
// fan_gov_pkg: shared types and the temperature-to-fan-level mapping for the fan speed governor.
package fan_gov_pkg;

    typedef logic [3:0] fan_level_t;

    localparam fan_level_t FAN_LEVEL_MAX = 4'd15;

    typedef enum logic {ACCUM, UPDATE} gov_state_t;

    function automatic fan_level_t fan_level(input logic [31:0] x, input logic [31:0] lo, input int sh);
        logic [31:0] d;
        d = (x - lo) >> sh;
        return (x <= lo) ? 4'd0 : (d > 32'd15) ? FAN_LEVEL_MAX : d[3:0];
    endfunction

endpackage

// File: rtl/fan_gov_avg.sv
// fan_gov_avg: windowed sample averager with valid/ready intake, UPDATE strobe and per-window over-temp flag.
module fan_gov_avg
    import fan_gov_pkg::*;
#(
    parameter int TEMP_W    = 12,
    parameter int AVG_LOG2  = 3,
    parameter int TEMP_CRIT = 2900
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [TEMP_W-1:0] i_temp,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_update,
    output logic [TEMP_W-1:0] o_win_avg,
    output logic [TEMP_W-1:0] o_avg,
    output logic              o_hot,
    output logic              o_win_hot
);

    gov_state_t                   r_state;
    logic [TEMP_W+AVG_LOG2-1:0]   r_acc;
    logic [AVG_LOG2-1:0]          r_cnt;
    logic                         r_ready;
    logic [TEMP_W-1:0]            r_avg;
    logic                         r_win_hot;
    logic                         w_accept;
    logic                         w_last;

    assign w_accept  = i_valid && r_ready;
    assign w_last    = w_accept && (&r_cnt);
    assign o_hot     = w_accept && (i_temp >= TEMP_W'(TEMP_CRIT));
    assign o_ready   = r_ready;
    assign o_update  = (r_state == UPDATE);
    assign o_win_avg = r_acc[TEMP_W+AVG_LOG2-1:AVG_LOG2];
    assign o_avg     = r_avg;
    assign o_win_hot = r_win_hot;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_avg     <= '0;
            r_win_hot <= 1'b0;
        end else if (r_state == ACCUM) begin
            r_ready <= !w_last;
            if (w_accept) begin
                r_acc <= r_acc + {{AVG_LOG2{1'b0}}, i_temp};
                r_cnt <= r_cnt + 1'b1;
            end
            if (o_hot) r_win_hot <= 1'b1;
            if (w_last) r_state <= UPDATE;
        end else begin
            r_avg     <= o_win_avg;
            r_acc     <= '0;
            r_win_hot <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= ACCUM;
        end
    end

endmodule

// File: rtl/fan_speed_governor.sv
// fan_speed_governor: averaged-temperature fan level governor with hysteresis, ramp, over-temp and override.
// Optional tachometer stall detection is enabled by defining FAN_GOV_TACH_EN.
module fan_speed_governor
    import fan_gov_pkg::*;
#(
    parameter int TEMP_W      = 12,
    parameter int AVG_LOG2    = 3,
    parameter int TEMP_LO     = 2600,
    parameter int TEMP_SHIFT  = 4,
    parameter int HYST        = 24,
    parameter int TEMP_CRIT   = 2900,
    parameter int MIN_SETTING = 4,
    parameter int STEP_CYCLES = 50000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [TEMP_W-1:0] temp_i,
    input  logic              temp_valid_i,
    output logic              temp_ready_o,
    input  logic              override_en_i,
    input  fan_level_t        override_setting_i,
    input  logic              tach_i,
    output fan_level_t        pwm_setting_o,
    output logic [TEMP_W-1:0] avg_temp_o,
    output logic              overtemp_o,
    output logic              fan_fault_o
);

    localparam int         CNT_W = $clog2(STEP_CYCLES);
    localparam fan_level_t MIN_L = fan_level_t'(MIN_SETTING);

    logic              w_update;
    logic              w_hot;
    logic              w_win_hot;
    logic [TEMP_W-1:0] w_win_avg;
    logic [TEMP_W:0]   w_sum;
    logic [TEMP_W-1:0] w_dn_x;
    fan_level_t        w_l_up;
    fan_level_t        w_l_dn;
    fan_level_t        w_up;
    fan_level_t        w_dn;
    logic              w_tick;
    logic              w_release;
    logic              w_ot_next;
    logic              w_fault_next;
    fan_level_t        r_set;
    fan_level_t        r_target;
    logic              r_overtemp;
    logic [CNT_W-1:0]  r_tick_cnt;

    fan_gov_avg #(
        .TEMP_W    (TEMP_W),
        .AVG_LOG2  (AVG_LOG2),
        .TEMP_CRIT (TEMP_CRIT)
    ) u_avg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_temp    (temp_i),
        .i_valid   (temp_valid_i),
        .o_ready   (temp_ready_o),
        .o_update  (w_update),
        .o_win_avg (w_win_avg),
        .o_avg     (avg_temp_o),
        .o_hot     (w_hot),
        .o_win_hot (w_win_hot)
    );

    // Decrease target is evaluated at a hotter point so small dips do not drop the level.
    always_comb begin
        w_sum  = {1'b0, w_win_avg} + (TEMP_W+1)'(HYST);
        w_dn_x = w_sum[TEMP_W] ? '1 : w_sum[TEMP_W-1:0];
        w_l_up = fan_level(32'(w_win_avg), 32'(TEMP_LO), TEMP_SHIFT);
        w_l_dn = fan_level(32'(w_dn_x), 32'(TEMP_LO), TEMP_SHIFT);
        w_up   = (w_l_up < MIN_L) ? MIN_L : w_l_up;
        w_dn   = (w_l_dn < MIN_L) ? MIN_L : w_l_dn;
    end

    assign w_tick        = (r_tick_cnt == CNT_W'(STEP_CYCLES - 1));
    assign w_release     = w_update && (w_win_avg < TEMP_W'(TEMP_CRIT - HYST)) && !w_win_hot;
    assign w_ot_next     = w_hot || (r_overtemp && !w_release);
    assign pwm_setting_o = r_set;
    assign overtemp_o    = r_overtemp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tick_cnt <= '0;
            r_overtemp <= 1'b0;
            r_set      <= FAN_LEVEL_MAX;
            r_target   <= FAN_LEVEL_MAX;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_overtemp <= w_ot_next;
            if (w_update) r_target <= (w_up > r_set) ? w_up : (w_dn < r_set) ? w_dn : r_target;
            if (w_fault_next || w_ot_next) r_set <= FAN_LEVEL_MAX;
            else if (override_en_i) r_set <= override_setting_i;
            else if (w_tick && r_set != r_target) r_set <= (r_set < r_target) ? r_set + 1'b1 : r_set - 1'b1;
        end
    end

`ifdef FAN_GOV_TACH_EN
    logic [2:0] r_tach;
    logic [7:0] r_edges;
    logic       r_zero_win;
    logic       r_fault;
    logic       w_edge;
    logic       w_zero;

    // An edge landing on the tick cycle still belongs to the window that is closing.
    assign w_edge       = r_tach[1] && !r_tach[2];
    assign w_zero       = (r_edges == 8'd0) && !w_edge && (r_set != 4'd0);
    assign w_fault_next = r_fault || (w_tick && w_zero && r_zero_win);
    assign fan_fault_o  = r_fault;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tach     <= '0;
            r_edges    <= '0;
            r_zero_win <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_tach  <= {r_tach[1:0], tach_i};
            r_fault <= w_fault_next;
            if (w_tick) begin
                r_edges    <= '0;
                r_zero_win <= w_zero;
            end else if (w_edge && r_edges != 8'hFF) begin
                r_edges <= r_edges + 1'b1;
            end
        end
    end
`else
    logic w_unused;

    assign w_unused     = tach_i;
    assign w_fault_next = 1'b0;
    assign fan_fault_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fan_speed_governor.sv
// tb_fan_speed_governor: directed checks of averaging, hysteresis, ramp, over-temp, override and reset.
module tb_fan_speed_governor;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [11:0] temp_i = '0;
    logic        temp_valid_i = 1'b0;
    logic        temp_ready_o;
    logic        override_en_i = 1'b0;
    logic [3:0]  override_setting_i = '0;
    logic        tach_i = 1'b0;
    logic        tach_run = 1'b1;
    logic [3:0]  pwm_setting_o;
    logic [11:0] avg_temp_o;
    logic        overtemp_o;
    logic        fan_fault_o;
    int          n_tests = 0;
    int          n_fail = 0;

    fan_speed_governor #(.STEP_CYCLES(16)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .temp_i             (temp_i),
        .temp_valid_i       (temp_valid_i),
        .temp_ready_o       (temp_ready_o),
        .override_en_i      (override_en_i),
        .override_setting_i (override_setting_i),
        .tach_i             (tach_i),
        .pwm_setting_o      (pwm_setting_o),
        .avg_temp_o         (avg_temp_o),
        .overtemp_o         (overtemp_o),
        .fan_fault_o        (fan_fault_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial forever begin
        repeat (4) @(negedge clk_i);
        if (tach_run) tach_i = ~tach_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [11:0] t);
        int n;
        @(negedge clk_i);
        temp_i = t;
        temp_valid_i = 1'b1;
        n = 0;
        while (!temp_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(temp_ready_o), 1);
        @(posedge clk_i);
        #1 temp_valid_i = 1'b0;
    endtask

    task automatic window(input logic [11:0] t, input logic [11:0] exp_avg);
        repeat (8) send(t);
        check("ready_in_update", 32'(temp_ready_o), 0);
        repeat (2) @(negedge clk_i);
        check("avg", 32'(avg_temp_o), 32'(exp_avg));
    endtask

    task automatic wait_pwm(input string tag, input logic [3:0] exp, input int budget);
        for (int n = 0; n < budget && pwm_setting_o !== exp; n++) @(negedge clk_i);
        check(tag, 32'(pwm_setting_o), 32'(exp));
    endtask

    task automatic hold_pwm(input string tag, input logic [3:0] exp);
        repeat (40) @(negedge clk_i);
        check(tag, 32'(pwm_setting_o), 32'(exp));
    endtask

    initial begin
        int n;
        #1 rst_ni = 1'b0;
        #2;
        check("rst_pwm", 32'(pwm_setting_o), 15);
        check("rst_avg", 32'(avg_temp_o), 0);
        check("rst_ot", 32'(overtemp_o), 0);
        check("rst_fault", 32'(fan_fault_o), 0);
        check("rst_ready", 32'(temp_ready_o), 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("ready_after_rst", 32'(temp_ready_o), 1);
        hold_pwm("idle_full", 15);

        // 2680: Up 5, Dn L(2704)=6 from 15 -> target 6
        window(12'd2680, 12'd2680);
        wait_pwm("ramp_14", 4'd14, 40);
        n = 0;
        while (pwm_setting_o == 4'd14 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("step_period", 32'(n), 16);
        check("ramp_13", 32'(pwm_setting_o), 13);
        wait_pwm("ramp_6", 4'd6, 200);
        hold_pwm("hold_6", 6);

        window(12'd2690, 12'd2690);
        hold_pwm("hyst_hold_6", 6);
        window(12'd2670, 12'd2670);
        wait_pwm("hyst_dn_5", 4'd5, 40);
        window(12'd2650, 12'd2650);
        wait_pwm("hyst_dn_4", 4'd4, 40);
        window(12'd2500, 12'd2500);
        hold_pwm("floor_4", 4);

        send(12'd2680);
        send(12'd2680);
        check("ot_before", 32'(overtemp_o), 0);
        send(12'd2900);
        check("ot_set", 32'(overtemp_o), 1);
        check("ot_pwm", 32'(pwm_setting_o), 15);
        repeat (5) send(12'd2680);
        repeat (2) @(negedge clk_i);
        check("ot_avg", 32'(avg_temp_o), 2707);
        check("ot_hold_hot_win", 32'(overtemp_o), 1);
        window(12'd2700, 12'd2700);
        check("ot_release", 32'(overtemp_o), 0);
        wait_pwm("ot_ramp_7", 4'd7, 200);
        hold_pwm("ot_hold_7", 7);

        @(negedge clk_i);
        override_en_i = 1'b1;
        override_setting_i = 4'd2;
        @(posedge clk_i);
        #1 check("ovr_latency", 32'(pwm_setting_o), 2);
        hold_pwm("ovr_hold", 2);
        send(12'd2950);
        check("ovr_ot_set", 32'(overtemp_o), 1);
        check("ovr_ot_pwm", 32'(pwm_setting_o), 15);
        repeat (7) send(12'd2700);
        repeat (2) @(negedge clk_i);
        check("ovr_ot_avg", 32'(avg_temp_o), 2731);
        check("ovr_ot_prio", 32'(pwm_setting_o), 15);
        window(12'd2700, 12'd2700);
        check("ovr_release_ot", 32'(overtemp_o), 0);
        check("ovr_release_pwm", 32'(pwm_setting_o), 2);
        @(negedge clk_i);
        override_en_i = 1'b0;
        wait_pwm("ovr_ramp_3", 4'd3, 20);
        wait_pwm("ovr_ramp_7", 4'd7, 100);
        hold_pwm("ovr_hold_7", 7);

        window(12'd2899, 12'd2899);
        check("crit_minus1_ot", 32'(overtemp_o), 0);
        wait_pwm("ramp_up_15", 4'd15, 200);

        repeat (3) send(12'd2500);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midrst_pwm", 32'(pwm_setting_o), 15);
        check("midrst_ready", 32'(temp_ready_o), 0);
        check("midrst_avg", 32'(avg_temp_o), 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        window(12'd2680, 12'd2680);
        wait_pwm("midrst_ramp_6", 4'd6, 200);
        check("no_fault_toggling", 32'(fan_fault_o), 0);

`ifdef FAN_GOV_TACH_EN
        @(negedge clk_i);
        tach_run = 1'b0;
        tach_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        check("stall_one_window", 32'(fan_fault_o), 0);
        repeat (20) @(negedge clk_i);
        check("stall_fault", 32'(fan_fault_o), 1);
        check("stall_pwm", 32'(pwm_setting_o), 15);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
